// File: rtl/sio_outbound_pkt_checker_pkg.sv
// Shared types and constants for the outbound SIO packet checker.
// Latency: n/a (declarations only).
// Backpressure: n/a; the checker is a passive monitor and never stalls the bus.
package sio_mon_pkg;

   // Lane granularity for parity: one parity bit covers 16 data bits
   localparam int LANE_W = 16;

   // err_code bit positions
   localparam int ERR_PAR  = 0;
   localparam int ERR_ORPH = 1;
   localparam int ERR_OVL  = 2;
   localparam int ERR_W    = 3;

   // Per-channel packet tracking state
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_PAYLOAD = 2'd2
   } ch_state_e;

endpackage

// File: rtl/sio_outbound_pkt_checker_if.sv
// Outbound SIO bus as seen by the checker: header qualifiers, data and lane parity.
// Latency: n/a (wires only).
// Backpressure: none; master drives every cycle, slave only observes.
interface sio_outbound_pkt_checker_if
   import sio_mon_pkg::*;
#(
   parameter int NUM_CH = 1,
   parameter int DATA_W = 128
);
   logic [NUM_CH-1:0]               hdr_vld;
   logic [NUM_CH-1:0]               datareq;
   logic [NUM_CH*DATA_W-1:0]        data;
   logic [NUM_CH*DATA_W/LANE_W-1:0] parity;

   modport master (output hdr_vld, output datareq, output data, output parity);
   modport slave  (input  hdr_vld, input  datareq, input  data, input  parity);
endinterface

// File: rtl/sio_outbound_pkt_checker_ch_tracker.sv
// Single-channel tracker: packet FSM, lane parity check, saturating counters, first-error capture.
// Latency: busy/pkt_done/counters/errors all reflect the cycle before (registered, 1 cycle).
// Backpressure: none; observes only, headers arriving mid-packet are flagged and dropped.
module sio_ch_tracker
   import sio_mon_pkg::*;
#(
   parameter int DATA_W  = 128,
   parameter int BEATS   = 4,
   parameter int CNT_W   = 16,
   parameter int PAR_ODD = 1
)
(
   input  logic                     iol2clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     clr_err,
   input  logic                     hdr_vld,
   input  logic                     datareq,
   input  logic [DATA_W-1:0]        data,
   input  logic [DATA_W/LANE_W-1:0] parity,
   output logic                     busy,
   output logic                     pkt_done,
   output logic [CNT_W-1:0]         data_pkt_cnt,
   output logic [CNT_W-1:0]         ack_pkt_cnt,
   output logic                     err_sticky,
   output logic [ERR_W-1:0]         err_code
);
   localparam int         NLANE     = DATA_W / LANE_W;
   localparam logic       PAR_BIT   = (PAR_ODD != 0);
   localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

   ch_state_e        state_q, state_d;
   logic [3:0]       beat_q, beat_d;
   logic             pkt_done_q, pkt_done_d;
   logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
   logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;
   logic             err_sticky_q, err_sticky_d;
   logic [ERR_W-1:0] err_code_q, err_code_d;

   logic             ack_hit, data_hit, par_bad;
   logic [ERR_W-1:0] err_new;

   // Any lane whose XOR with its parity bit differs from the selected sense is bad
   always_comb begin
      par_bad = 1'b0;
      for (int i = 0; i < NLANE; i++) begin
         if (((^data[i*LANE_W +: LANE_W]) ^ parity[i]) != PAR_BIT) par_bad = 1'b1;
      end
   end

   // Packet FSM: header -> one gap cycle -> BEATS payload cycles
   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      ack_hit  = 1'b0;
      data_hit = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hdr_vld) begin
               if (datareq) state_d = ST_WAIT;
               else         ack_hit = 1'b1;
            end
         end
         ST_WAIT: begin
            state_d = ST_PAYLOAD;
            beat_d  = 4'd0;
         end
         ST_PAYLOAD: begin
            if (beat_q == LAST_BEAT) begin
               state_d  = ST_IDLE;
               beat_d   = 4'd0;
               data_hit = 1'b1;
            end else begin
               beat_d = beat_q + 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            beat_d  = 4'd0;
         end
      endcase
   end

   // Counters and completion pulse; FSM keeps running when disabled so alignment survives
   always_comb begin
      data_cnt_d = data_cnt_q;
      ack_cnt_d  = ack_cnt_q;
      pkt_done_d = enable & (ack_hit | data_hit);
      if (enable && data_hit && (data_cnt_q != '1)) data_cnt_d = data_cnt_q + CNT_W'(1);
      if (enable && ack_hit  && (ack_cnt_q  != '1)) ack_cnt_d  = ack_cnt_q  + CNT_W'(1);
   end

   // Error detection and first-error capture; clear wins over a same-cycle error
   always_comb begin
      err_new           = '0;
      err_new[ERR_PAR]  = par_bad & ((state_q == ST_IDLE & hdr_vld) | (state_q == ST_PAYLOAD));
      err_new[ERR_ORPH] = datareq & ~hdr_vld & ((state_q == ST_IDLE) | (state_q == ST_WAIT));
      err_new[ERR_OVL]  = hdr_vld & ((state_q == ST_WAIT) | (state_q == ST_PAYLOAD));
      err_sticky_d      = err_sticky_q;
      err_code_d        = err_code_q;
      if (clr_err) begin
         err_sticky_d = 1'b0;
         err_code_d   = '0;
      end else if (enable && !err_sticky_q && (err_new != '0)) begin
         err_sticky_d = 1'b1;
         err_code_d   = err_new;
      end
   end

   // State register with asynchronous reset
   always_ff @(posedge iol2clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         beat_q       <= '0;
         pkt_done_q   <= 1'b0;
         data_cnt_q   <= '0;
         ack_cnt_q    <= '0;
         err_sticky_q <= 1'b0;
         err_code_q   <= '0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         pkt_done_q   <= pkt_done_d;
         data_cnt_q   <= data_cnt_d;
         ack_cnt_q    <= ack_cnt_d;
         err_sticky_q <= err_sticky_d;
         err_code_q   <= err_code_d;
      end
   end

   assign busy         = (state_q != ST_IDLE);
   assign pkt_done     = pkt_done_q;
   assign data_pkt_cnt = data_cnt_q;
   assign ack_pkt_cnt  = ack_cnt_q;
   assign err_sticky   = err_sticky_q;
   assign err_code     = err_code_q;

endmodule

// File: rtl/sio_outbound_pkt_checker.sv
// Outbound SIO packet checker: NUM_CH independent channel trackers side by side.
// Latency: 1 cycle, all outputs registered inside each tracker.
// Backpressure: none; passive monitor of the outbound bus.
module sio_outbound_pkt_checker
   import sio_mon_pkg::*;
#(
   parameter int NUM_CH  = 1,
   parameter int DATA_W  = 128,
   parameter int BEATS   = 4,
   parameter int CNT_W   = 16,
   parameter int PAR_ODD = 1
)
(
   input  logic                    iol2clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    clr_err,
   sio_outbound_pkt_checker_if.slave sio,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       pkt_done,
   output logic [NUM_CH*CNT_W-1:0] data_pkt_cnt,
   output logic [NUM_CH*CNT_W-1:0] ack_pkt_cnt,
   output logic [NUM_CH-1:0]       err_sticky,
   output logic [NUM_CH*ERR_W-1:0] err_code
);
   localparam int NLANE = DATA_W / LANE_W;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      sio_ch_tracker #(
         .DATA_W  (DATA_W),
         .BEATS   (BEATS),
         .CNT_W   (CNT_W),
         .PAR_ODD (PAR_ODD)
      ) u_trk (
         .iol2clk      (iol2clk),
         .rst          (rst),
         .enable       (enable),
         .clr_err      (clr_err),
         .hdr_vld      (sio.hdr_vld[c]),
         .datareq      (sio.datareq[c]),
         .data         (sio.data[c*DATA_W +: DATA_W]),
         .parity       (sio.parity[c*NLANE +: NLANE]),
         .busy         (busy[c]),
         .pkt_done     (pkt_done[c]),
         .data_pkt_cnt (data_pkt_cnt[c*CNT_W +: CNT_W]),
         .ack_pkt_cnt  (ack_pkt_cnt[c*CNT_W +: CNT_W]),
         .err_sticky   (err_sticky[c]),
         .err_code     (err_code[c*ERR_W +: ERR_W])
      );
   end

endmodule

// File: tb/tb_sio_outbound_pkt_checker.sv
// Directed bench for sio_outbound_pkt_checker: two channels, 2-bit counters, odd parity.
// Latency: outputs checked 1 time unit after the rising edge that produced them.
// Backpressure: n/a; the bench drives the bus every cycle.
module tb_sio_outbound_pkt_checker;
   localparam int NONE = 99;

   logic       iol2clk, rst, enable, clr_err;
   logic [1:0] busy, pkt_done, err_sticky;
   logic [3:0] data_pkt_cnt, ack_pkt_cnt;
   logic [5:0] err_code;
   logic [127:0] flip17;
   int n_total, n_pass;

   sio_outbound_pkt_checker_if #(.NUM_CH(2), .DATA_W(128)) bus ();

   sio_outbound_pkt_checker #(
      .NUM_CH(2), .DATA_W(128), .BEATS(4), .CNT_W(2), .PAR_ODD(1)
   ) dut (
      .iol2clk      (iol2clk),
      .rst          (rst),
      .enable       (enable),
      .clr_err      (clr_err),
      .sio          (bus),
      .busy         (busy),
      .pkt_done     (pkt_done),
      .data_pkt_cnt (data_pkt_cnt),
      .ack_pkt_cnt  (ack_pkt_cnt),
      .err_sticky   (err_sticky),
      .err_code     (err_code)
   );

   initial begin
      iol2clk = 1'b0;
      forever #5 iol2clk = ~iol2clk;
   end

   // Odd parity: each lane XOR its parity bit must be 1, so parity = ~^lane
   function automatic logic [7:0] good_par(input logic [127:0] d);
      logic [7:0] p;
      for (int i = 0; i < 8; i++) p[i] = ~(^d[i*16 +: 16]);
      return p;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge iol2clk);
      #1;
   endtask

   task automatic drv(input int ch, input logic h, input logic d,
                      input logic [127:0] dat, input logic [127:0] fl);
      bus.hdr_vld[ch]          = h;
      bus.datareq[ch]          = d;
      bus.data[ch*128 +: 128]  = dat ^ fl;
      bus.parity[ch*8 +: 8]    = good_par(dat);
   endtask

   // One cycle of a ch0 data packet: cyc 0 header, 1 gap, 2..5 payload beats 0..3
   task automatic pkt_cycle(input int cyc, input int bad_beat, input int ovl_beat);
      logic [31:0]  w;
      logic [127:0] dat, fl;
      w   = 32'h9e37_79b9 * (cyc + 1);
      dat = {w, ~w, w ^ 32'h5a5a_a5a5, w + 32'd7};
      fl  = (cyc - 2 == bad_beat) ? flip17 : '0;
      if (cyc == 0)                        drv(0, 1'b1, 1'b1, dat, '0);
      else if (cyc >= 2 && cyc - 2 == ovl_beat) drv(0, 1'b1, 1'b0, dat, fl);
      else                                 drv(0, 1'b0, 1'b0, dat, fl);
      tick();
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      flip17  = 128'd1 << 17;
      rst = 1'b1; enable = 1'b1; clr_err = 1'b0;
      drv(0, 1'b0, 1'b0, '0, '0);
      drv(1, 1'b0, 1'b0, '0, '0);
      tick(); tick();

      // Reset state
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_done",  32'(pkt_done), 32'h0);
      chk("rst_cnt",   32'({data_pkt_cnt, ack_pkt_cnt}), 32'h0);
      chk("rst_err",   32'({err_sticky, err_code}), 32'h0);
      rst = 1'b0;

      // Write-ack accepted on the first edge after reset
      drv(0, 1'b1, 1'b0, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, '0);
      tick();
      chk("ack_done",  32'(pkt_done), 32'h1);
      chk("ack_cnt",   32'(ack_pkt_cnt[1:0]), 32'h1);
      chk("ack_busy",  32'(busy), 32'h0);
      drv(0, 1'b0, 1'b0, '0, '0);
      tick();
      chk("ack_done_once", 32'(pkt_done), 32'h0);
      chk("ack_noerr",     32'(err_sticky), 32'h0);

      // Clean data packet: busy cycles 1-5, pkt_done cycle 6
      for (int cyc = 0; cyc < 6; cyc++) begin
         pkt_cycle(cyc, NONE, NONE);
         chk($sformatf("dp_busy_c%0d", cyc + 1), 32'(busy[0]), (cyc < 5) ? 32'h1 : 32'h0);
         chk($sformatf("dp_done_c%0d", cyc + 1), 32'(pkt_done[0]), (cyc == 5) ? 32'h1 : 32'h0);
      end
      chk("dp_cnt",   32'(data_pkt_cnt[1:0]), 32'h1);
      chk("dp_noerr", 32'(err_sticky), 32'h0);
      drv(0, 1'b0, 1'b0, '0, '0);

      // Parity error on beat 2 (bit 17 flipped)
      for (int cyc = 0; cyc < 6; cyc++) begin
         pkt_cycle(cyc, 2, NONE);
         if (cyc == 3) chk("par_not_yet", 32'(err_sticky[0]), 32'h0);
         if (cyc == 4) begin
            chk("par_sticky", 32'(err_sticky[0]), 32'h1);
            chk("par_code",   32'(err_code[2:0]), 32'h1);
         end
      end
      chk("par_cnt",  32'(data_pkt_cnt[1:0]), 32'h2);
      chk("par_done", 32'(pkt_done[0]), 32'h1);
      drv(0, 1'b0, 1'b0, '0, '0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("clr_sticky", 32'(err_sticky), 32'h0);
      chk("clr_code",   32'(err_code), 32'h0);

      // Header overlap on beat 1, then an orphan datareq that must not overwrite
      for (int cyc = 0; cyc < 6; cyc++) begin
         pkt_cycle(cyc, NONE, 1);
         if (cyc == 3) begin
            chk("ovl_code", 32'(err_code[2:0]), 32'h4);
            chk("ovl_busy", 32'(busy[0]), 32'h1);
         end
      end
      chk("ovl_data_cnt", 32'(data_pkt_cnt[1:0]), 32'h3);
      chk("ovl_ack_cnt",  32'(ack_pkt_cnt[1:0]), 32'h1);
      drv(0, 1'b0, 1'b1, '0, '0);
      tick();
      chk("orph_keep_code", 32'(err_code[2:0]), 32'h4);
      chk("orph_busy",      32'(busy[0]), 32'h0);

      // Clear beats a same-cycle orphan; the orphan is lost
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      drv(0, 1'b0, 1'b0, '0, '0);
      tick();
      chk("clr_prio_sticky", 32'(err_sticky[0]), 32'h0);
      drv(0, 1'b0, 1'b1, '0, '0);
      tick();
      chk("orph_code", 32'(err_code[2:0]), 32'h2);
      drv(0, 1'b0, 1'b0, '0, '0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;

      // Asynchronous reset in the middle of beat 2
      for (int cyc = 0; cyc < 4; cyc++) pkt_cycle(cyc, NONE, NONE);
      chk("mid_busy_pre", 32'(busy[0]), 32'h1);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_cnt",  32'({data_pkt_cnt, ack_pkt_cnt}), 32'h0);
      #2 rst = 1'b0;
      for (int cyc = 0; cyc < 6; cyc++) pkt_cycle(cyc, NONE, NONE);
      chk("post_rst_done", 32'(pkt_done[0]), 32'h1);
      chk("post_rst_cnt",  32'(data_pkt_cnt[1:0]), 32'h1);
      chk("post_rst_err",  32'(err_sticky[0]), 32'h0);

      // Overlap header with bad parity in one cycle sets both bits
      for (int cyc = 0; cyc < 6; cyc++) begin
         pkt_cycle(cyc, 1, 1);
         if (cyc == 3) chk("multi_code", 32'(err_code[2:0]), 32'h5);
      end
      chk("multi_cnt", 32'(data_pkt_cnt[1:0]), 32'h2);
      drv(0, 1'b0, 1'b0, '0, '0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;

      // enable=0: FSM still tracks, nothing counted or captured
      enable = 1'b0;
      drv(0, 1'b0, 1'b1, '0, '0);
      tick();
      chk("dis_orph", 32'(err_sticky[0]), 32'h0);
      drv(0, 1'b1, 1'b0, '0, '0);
      tick();
      chk("dis_ack_done", 32'(pkt_done[0]), 32'h0);
      chk("dis_ack_cnt",  32'(ack_pkt_cnt[1:0]), 32'h0);
      for (int cyc = 0; cyc < 6; cyc++) begin
         pkt_cycle(cyc, NONE, NONE);
         chk($sformatf("dis_busy_c%0d", cyc + 1), 32'(busy[0]), (cyc < 5) ? 32'h1 : 32'h0);
         chk($sformatf("dis_done_c%0d", cyc + 1), 32'(pkt_done[0]), 32'h0);
      end
      chk("dis_data_cnt", 32'(data_pkt_cnt[1:0]), 32'h2);
      enable = 1'b1;
      drv(0, 1'b1, 1'b0, '0, '0);
      tick();
      chk("reen_done", 32'(pkt_done[0]), 32'h1);
      chk("reen_ack",  32'(ack_pkt_cnt[1:0]), 32'h1);
      chk("reen_err",  32'(err_sticky[0]), 32'h0);
      drv(0, 1'b0, 1'b0, '0, '0);

      // Saturation on ch0 with ch1 idle, then ch1 on its own
      rst = 1'b1;
      #1 rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drv(0, 1'b1, 1'b0, {4{32'(k) * 32'h1357_9bdf}}, '0);
         tick();
      end
      drv(0, 1'b0, 1'b0, '0, '0);
      tick();
      chk("sat_ch0", 32'(ack_pkt_cnt[1:0]), 32'h3);
      chk("sat_ch1", 32'(ack_pkt_cnt[3:2]), 32'h0);
      chk("sat_ch1_busy", 32'(busy[1]), 32'h0);
      drv(1, 1'b1, 1'b0, 128'hdead_beef_0000_ffff_1234_5678_a5a5_5a5a, '0);
      tick();
      chk("ch1_done", 32'(pkt_done), 32'h2);
      drv(1, 1'b0, 1'b0, '0, '0);
      tick();
      chk("ch1_cnt",      32'(ack_pkt_cnt[3:2]), 32'h1);
      chk("ch1_ch0_keep", 32'(ack_pkt_cnt[1:0]), 32'h3);
      chk("ch1_noerr",    32'(err_sticky), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
